// File: rtl/square_wave_analyzer.sv
// Square-wave analyzer: recovers the frequency word and amplitude
// from a sampled square-wave stream by timing its half-periods.
module square_wave_analyzer #(
    parameter int unsigned CLOCK_FREQUENCY = 50000000,
    parameter int unsigned TIMEOUT_CYCLES  = 67108864
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] sq_wave,
    output logic [15:0] frequency,
    output logic [30:0] amplitude,
    output logic        meas_valid,
    output logic        locked
);

    typedef enum logic [1:0] {
        SEEK,
        FIRST,
        PAIR,
        LOCK
    } trk_e;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } div_e;

    logic        lvl;
    logic        lvl_q;
    logic        edge_det;
    logic        rise;
    logic        match;
    logic        timeout;
    logic        start;
    logic        clear_freq;

    logic [31:0] hp_cnt_q, hp_cnt_d;
    logic [31:0] prev_hp_q, prev_hp_d;
    logic [30:0] amp_raw_q, amp_raw_d;
    trk_e        trk_q, trk_d;

    div_e        div_q, div_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [30:0] damp_q, damp_d;
    logic [32:0] shifted;
    logic        ge;

    logic [15:0] freq_q, freq_d;
    logic [30:0] amp_q, amp_d;
    logic        mv_q, mv_d;

    assign lvl      = |sq_wave;
    assign edge_det = lvl ^ lvl_q;
    assign rise     = lvl & ~lvl_q;
    assign match    = (hp_cnt_q == prev_hp_q);
    assign timeout  = (hp_cnt_q >= 32'(TIMEOUT_CYCLES));

    // an edge in the same cycle as a timeout takes priority
    assign clear_freq = (trk_q != SEEK) && !edge_det && timeout;

    always_comb begin
        hp_cnt_d  = hp_cnt_q;
        prev_hp_d = prev_hp_q;
        amp_raw_d = amp_raw_q;
        trk_d     = trk_q;
        start     = 1'b0;
        if (edge_det) begin
            hp_cnt_d = 32'd1;
        end else if (hp_cnt_q != 32'hFFFF_FFFF) begin
            hp_cnt_d = hp_cnt_q + 32'd1;
        end
        if (rise) begin
            amp_raw_d = sq_wave[31:1];
        end
        if (edge_det) begin
            unique case (trk_q)
                SEEK: begin
                    trk_d = FIRST;
                end
                FIRST: begin
                    prev_hp_d = hp_cnt_q;
                    trk_d     = PAIR;
                end
                PAIR, LOCK: begin
                    prev_hp_d = hp_cnt_q;
                    if (match) begin
                        trk_d = LOCK;
                        start = 1'b1;
                    end else begin
                        trk_d = PAIR;
                    end
                end
            endcase
        end else if (clear_freq) begin
            trk_d = SEEK;
        end
    end

    // restoring divider: quo_q starts as the dividend and shifts
    // into the quotient one bit per cycle
    assign shifted = {rem_q, quo_q[31]};
    assign ge      = (shifted >= {1'b0, dvs_q});

    always_comb begin
        div_d  = div_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        damp_d = damp_q;
        freq_d = freq_q;
        amp_d  = amp_q;
        mv_d   = 1'b0;
        unique case (div_q)
            IDLE: begin
                if (start) begin
                    div_d  = DIV;
                    rem_d  = '0;
                    quo_d  = 32'(CLOCK_FREQUENCY);
                    dvs_d  = hp_cnt_q;
                    cnt_d  = '0;
                    damp_d = amp_raw_d;
                end
            end
            DIV: begin
                if (ge) begin
                    rem_d = 32'(shifted - {1'b0, dvs_q});
                end else begin
                    rem_d = shifted[31:0];
                end
                quo_d = {quo_q[30:0], ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    div_d = DONE;
                end
            end
            DONE: begin
                if (|quo_q[31:16]) begin
                    freq_d = 16'hFFFF;
                end else begin
                    freq_d = quo_q[15:0];
                end
                amp_d = damp_q;
                mv_d  = 1'b1;
                div_d = IDLE;
            end
            default: begin
                div_d = IDLE;
            end
        endcase
        if (clear_freq) begin
            freq_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_q     <= 1'b0;
            hp_cnt_q  <= '0;
            prev_hp_q <= '0;
            amp_raw_q <= '0;
            trk_q     <= SEEK;
            div_q     <= IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            damp_q    <= '0;
            freq_q    <= '0;
            amp_q     <= '0;
            mv_q      <= 1'b0;
        end else begin
            lvl_q     <= lvl;
            hp_cnt_q  <= hp_cnt_d;
            prev_hp_q <= prev_hp_d;
            amp_raw_q <= amp_raw_d;
            trk_q     <= trk_d;
            div_q     <= div_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            damp_q    <= damp_d;
            freq_q    <= freq_d;
            amp_q     <= amp_d;
            mv_q      <= mv_d;
        end
    end

    assign frequency  = freq_q;
    assign amplitude  = amp_q;
    assign meas_valid = mv_q;
    assign locked     = (trk_q == LOCK);

endmodule

// File: tb/tb_square_wave_analyzer.sv
// Scoreboard bench for square_wave_analyzer: a scaled-clock instance
// and a saturating instance, driven by directed half-period patterns.
module tb_square_wave_analyzer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] sq;
    logic [31:0] sq2;
    logic [15:0] f0, f1;
    logic [30:0] a0, a1;
    logic        mv0, mv1, lk0, lk1;

    square_wave_analyzer #(
        .CLOCK_FREQUENCY(5000),
        .TIMEOUT_CYCLES (6000)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .sq_wave   (sq),
        .frequency (f0),
        .amplitude (a0),
        .meas_valid(mv0),
        .locked    (lk0)
    );

    square_wave_analyzer #(
        .CLOCK_FREQUENCY(3500000),
        .TIMEOUT_CYCLES (4000000)
    ) u_sat (
        .clk       (clk),
        .reset     (reset),
        .sq_wave   (sq2),
        .frequency (f1),
        .amplitude (a1),
        .meas_valid(mv1),
        .locked    (lk1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [15:0] f;
        logic [30:0] a;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mv0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mv0_unexpected got pulse at cycle %0d want none", cyc);
            end else begin
                e0 = q0.pop_front();
                chk("mv0_cycle", cyc, e0.c);
                chk("mv0_freq", {16'd0, f0}, {16'd0, e0.f});
                chk("mv0_amp", {1'b0, a0}, {1'b0, e0.a});
            end
        end
        if (mv1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mv1_unexpected got pulse at cycle %0d want none", cyc);
            end else begin
                e1 = q1.pop_front();
                chk("mv1_cycle", cyc, e1.c);
                chk("mv1_freq", {16'd0, f1}, {16'd0, e1.f});
                chk("mv1_amp", {1'b0, a1}, {1'b0, e1.a});
            end
        end
    end

    // one half-period: level v held for n cycles starting at edge cycle E;
    // a pushed result is due at E+34, lock state is checked at E+1
    task automatic half(input int sel, input logic [31:0] v, input int n,
                        input bit push, input logic [15:0] f,
                        input logic [30:0] a, input logic lk);
        int   e;
        exp_t x;
        @(posedge clk);
        #1;
        if (sel == 0) sq = v;
        else sq2 = v;
        e = cyc;
        if (push) begin
            x.c = e + 34;
            x.f = f;
            x.a = a;
            if (sel == 0) q0.push_back(x);
            else q1.push_back(x);
        end
        @(posedge clk);
        #1;
        if (sel == 0) chk("lock0", {31'd0, lk0}, {31'd0, lk});
        else chk("lock1", {31'd0, lk1}, {31'd0, lk});
        repeat (n - 2) @(posedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        reset = 1'b1;
        sq    = '0;
        sq2   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_freq", {16'd0, f0}, 0);
        chk("rst_amp", {1'b0, a0}, 0);
        chk("rst_mv", {31'd0, mv0}, 0);
        chk("rst_lock", {31'd0, lk0}, 0);
        chk("rst_freq1", {16'd0, f1}, 0);
        chk("rst_lock1", {31'd0, lk1}, 0);
        reset = 1'b0;
        repeat (5) @(posedge clk);

        // saturation: 3500000 / 50 = 70000 -> 65535
        half(1, 6, 50, 0, 0, 0, 0);
        half(1, 0, 50, 0, 0, 0, 0);
        half(1, 6, 50, 1, 16'hFFFF, 3, 1);
        half(1, 0, 50, 1, 16'hFFFF, 3, 1);

        // 5000 / 50 = 100, amplitude 2000 >> 1
        half(0, 2000, 50, 0, 0, 0, 0);
        half(0, 0, 50, 0, 0, 0, 0);
        half(0, 2000, 50, 1, 100, 1000, 1);
        half(0, 0, 50, 1, 100, 1000, 1);
        half(0, 2000, 50, 1, 100, 1000, 1);
        half(0, 0, 50, 1, 100, 1000, 1);

        // rate change to 40: 5000 / 40 = 125
        half(0, 2000, 40, 1, 100, 1000, 1);
        half(0, 0, 40, 0, 0, 0, 0);
        half(0, 2000, 40, 1, 125, 1000, 1);
        half(0, 0, 40, 1, 125, 1000, 1);
        half(0, 2000, 40, 1, 125, 1000, 1);

        // timeout: held low 6000 cycles
        half(0, 0, 6000, 1, 125, 1000, 1);
        @(posedge clk);
        #1;
        chk("to_lock_before", {31'd0, lk0}, 1);
        @(posedge clk);
        #1;
        chk("to_lock_after", {31'd0, lk0}, 0);
        chk("to_freq", {16'd0, f0}, 0);
        chk("to_amp", {1'b0, a0}, 1000);

        // 5000 / 1666 = 3, amplitude 2 >> 1
        half(0, 2, 1666, 0, 0, 0, 0);
        half(0, 0, 1666, 0, 0, 0, 0);
        half(0, 2, 1666, 1, 3, 1, 1);
        half(0, 0, 1666, 1, 3, 1, 1);

        // reset 10 cycles into a division
        @(posedge clk);
        #1;
        sq = 2;
        e  = cyc;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_div_cycle", cyc, e + 10);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_freq", {16'd0, f0}, 0);
        chk("mr_amp", {1'b0, a0}, 0);
        chk("mr_mv", {31'd0, mv0}, 0);
        chk("mr_lock", {31'd0, lk0}, 0);
        reset = 1'b0;
        sq    = '0;
        repeat (100) @(posedge clk);

        half(0, 2000, 50, 0, 0, 0, 0);
        half(0, 0, 50, 0, 0, 0, 0);
        half(0, 2000, 50, 1, 100, 1000, 1);
        half(0, 0, 50, 1, 100, 1000, 1);

        repeat (60) @(posedge clk);
        #1;
        chk("queue_empty", q0.size() + q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
